// File: rtl/inv93_pkg.sv
// Shared types and constants for the inv93 loop-invariant monitor.
package inv93_pkg;

   localparam int W_DEF = 11;

   typedef enum logic [1:0] {
      INIT,
      RUN,
      DONE,
      FAIL
   } state_e;

   typedef enum logic [1:0] {
      STEP_HOLD,
      STEP_ADV12,
      STEP_ADV21,
      STEP_ILLEGAL
   } step_e;

   localparam logic [2:0] ERR_NONE  = 3'd0;
   localparam logic [2:0] ERR_INIT  = 3'd1;
   localparam logic [2:0] ERR_STEP  = 3'd2;
   localparam logic [2:0] ERR_INV   = 3'd3;
   localparam logic [2:0] ERR_BOUND = 3'd4;
   localparam logic [2:0] ERR_NCHG  = 3'd5;

endpackage

// File: rtl/inv93_monitor_if.sv
// Observation bus between the loop datapath (master) and the monitor (slave).
// INV93_MON_HIST_EN adds the per-direction advance counters cnt12/cnt21.
interface inv93_monitor_if
   import inv93_pkg::*;
#(
   parameter int W = W_DEF
);
   logic [W-1:0] i;
   logic [W-1:0] x;
   logic [W-1:0] y;
   logic [W-1:0] n;
   logic         done;
   logic         fail;
   logic [2:0]   err_code;
   logic [W-1:0] step_cnt;
   logic [W-1:0] fail_step;
`ifdef INV93_MON_HIST_EN
   logic [W-1:0] cnt12;
   logic [W-1:0] cnt21;
`endif

   modport master (
      output i, x, y, n,
      input  done, fail, err_code, step_cnt, fail_step
`ifdef INV93_MON_HIST_EN
      , input cnt12, cnt21
`endif
   );

   modport slave (
      input  i, x, y, n,
      output done, fail, err_code, step_cnt, fail_step
`ifdef INV93_MON_HIST_EN
      , output cnt12, cnt21
`endif
   );
endinterface

// File: rtl/inv93_step_chk.sv
// Combinational step classifier: hold / (1,2) advance / (2,1) advance / illegal,
// plus the (x+y) == 3*i invariant on the current sample, all modulo 2^W.
module inv93_step_chk
   import inv93_pkg::*;
#(
   parameter int W = W_DEF
) (
   input  logic [W-1:0] prev_i,
   input  logic [W-1:0] prev_x,
   input  logic [W-1:0] prev_y,
   input  logic [W-1:0] cur_i,
   input  logic [W-1:0] cur_x,
   input  logic [W-1:0] cur_y,
   output step_e        step,
   output logic         inv_ok
);
   logic [W-1:0] di, dx, dy, sum_xy, tri_i;

   assign di = cur_i - prev_i;
   assign dx = cur_x - prev_x;
   assign dy = cur_y - prev_y;

   // 3*i is built at W+2 bits so the shift/add cannot overflow before wrapping
   assign tri_i  = W'(({2'b00, cur_i} << 1) + {2'b00, cur_i});
   assign sum_xy = cur_x + cur_y;
   assign inv_ok = (sum_xy == tri_i);

   always_comb begin
      // NOTE: assigning a default first keeps every path covered, so no latch is inferred.
      step = STEP_ILLEGAL;
      if (di == '0 && dx == '0 && dy == '0)
         step = STEP_HOLD;
      else if (di == W'(1) && dx == W'(1) && dy == W'(2))
         step = STEP_ADV12;
      else if (di == W'(1) && dx == W'(2) && dy == W'(1))
         step = STEP_ADV21;
   end
endmodule

// File: rtl/inv93_monitor.sv
// Loop-invariant monitor: registers each sample, checks it against the previous one
// one cycle later and latches the first violation. Option: INV93_MON_HIST_EN.
module inv93_monitor
   import inv93_pkg::*;
#(
   parameter int W = W_DEF
) (
   input  logic           clk,
   input  logic           rst,
   inv93_monitor_if.slave mon
);
   logic [W-1:0] cur_i, cur_x, cur_y, cur_n;
   logic [W-1:0] prev_i, prev_x, prev_y, prev_n;
   logic         cur_vld;
   state_e       state, state_nxt;
   step_e        step;
   logic         inv_ok, adv;
   logic [2:0]   err_q, err_nxt, viol;
   logic [W-1:0] step_q, fstep_q, fstep_nxt;

   inv93_step_chk #(.W(W)) u_step_chk (
      .prev_i(prev_i), .prev_x(prev_x), .prev_y(prev_y),
      .cur_i (cur_i),  .cur_x (cur_x),  .cur_y (cur_y),
      .step  (step),   .inv_ok(inv_ok)
   );

   // Sample pipeline: cur_vld marks that cur_* holds a real post-reset sample.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         {cur_i, cur_x, cur_y, cur_n}     <= '0;
         {prev_i, prev_x, prev_y, prev_n} <= '0;
         cur_vld                          <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments let prev_* capture the old cur_* on the same edge.
         {prev_i, prev_x, prev_y, prev_n} <= {cur_i, cur_x, cur_y, cur_n};
         {cur_i, cur_x, cur_y, cur_n}     <= {mon.i, mon.x, mon.y, mon.n};
         cur_vld                          <= 1'b1;
      end
   end

   always_comb begin
      state_nxt = state;
      err_nxt   = err_q;
      fstep_nxt = fstep_q;
      adv       = 1'b0;
      viol      = ERR_NONE;
      unique case (state)
         INIT: if (cur_vld) begin
            if (cur_i == '0 && cur_x == '0 && cur_y == '0)
               state_nxt = (cur_n == '0) ? DONE : RUN;
            else
               viol = ERR_INIT;
         end
         RUN: begin
            if (cur_n != prev_n)          viol = ERR_NCHG;
            else if (cur_i > cur_n)       viol = ERR_BOUND;
            else if (step == STEP_ILLEGAL) viol = ERR_STEP;
            else if (!inv_ok)             viol = ERR_INV;
            else if (step != STEP_HOLD) begin
               adv = 1'b1;
               if (cur_i == cur_n) state_nxt = DONE;
            end
         end
         DONE: begin
            if (step != STEP_HOLD || cur_n != prev_n) viol = ERR_STEP;
            else if (!inv_ok)                          viol = ERR_INV;
         end
         FAIL: ;
         default: ;
      endcase
      if (viol != ERR_NONE) begin
         state_nxt = FAIL;
         err_nxt   = viol;
         fstep_nxt = cur_i;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= INIT;
         err_q   <= ERR_NONE;
         step_q  <= '0;
         fstep_q <= '0;
      end else begin
         state   <= state_nxt;
         err_q   <= err_nxt;
         fstep_q <= fstep_nxt;
         if (adv) step_q <= step_q + W'(1);
      end
   end

   assign mon.done      = (state == DONE);
   assign mon.fail      = (state == FAIL);
   assign mon.err_code  = err_q;
   assign mon.step_cnt  = step_q;
   assign mon.fail_step = fstep_q;

`ifdef INV93_MON_HIST_EN
   logic [W-1:0] cnt12_q, cnt21_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt12_q <= '0;
         cnt21_q <= '0;
      end else if (adv) begin
         if (step == STEP_ADV12) cnt12_q <= cnt12_q + W'(1);
         else                    cnt21_q <= cnt21_q + W'(1);
      end
   end

   assign mon.cnt12 = cnt12_q;
   assign mon.cnt21 = cnt21_q;
`endif
endmodule

// File: tb/tb_inv93_monitor.sv
// Directed bench for inv93_monitor: legal runs, latency, violation codes,
// priority, full-range wrap and asynchronous mid-run reset.
module tb_inv93_monitor;
   import inv93_pkg::*;

   localparam int W = 11;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_vec = 0;
   int   n_bad = 0;

   inv93_monitor_if #(.W(W)) bus ();

   inv93_monitor #(.W(W)) dut (
      .clk(clk),
      .rst(rst),
      .mon(bus.slave)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Drive one sample at a negedge and wait until the next negedge.
   task automatic put(input int i, input int x, input int y, input int n);
      bus.i = W'(i);
      bus.x = W'(x);
      bus.y = W'(y);
      bus.n = W'(n);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst   = 1'b1;
      bus.i = '0;
      bus.x = '0;
      bus.y = '0;
      bus.n = '0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic check_outputs(input string tag, input int d, input int f, input int e,
                                input int sc, input int fs);
      check({tag, ".done"},      32'(bus.done),      32'(d));
      check({tag, ".fail"},      32'(bus.fail),      32'(f));
      check({tag, ".err_code"},  32'(bus.err_code),  32'(e));
      check({tag, ".step_cnt"},  32'(bus.step_cnt),  32'(sc));
      check({tag, ".fail_step"}, 32'(bus.fail_step), 32'(fs));
   endtask

   initial begin
      logic [W-1:0] ax, ay;

      // Reset state
      bus.i = '0; bus.x = '0; bus.y = '0; bus.n = '0;
      @(negedge clk);
      check_outputs("reset", 0, 0, 0, 0, 0);
      do_reset();

      // n=5 legal run
      put(0, 0, 0, 5); put(1, 1, 2, 5); put(2, 3, 3, 5);
      put(3, 4, 5, 5); put(4, 6, 6, 5); put(5, 7, 8, 5);
      check("run5.done_late", 32'(bus.done), 32'd0);
      put(5, 7, 8, 5);
      check_outputs("run5", 1, 0, 0, 5, 0);
`ifdef INV93_MON_HIST_EN
      check("run5.cnt12", 32'(bus.cnt12), 32'd3);
      check("run5.cnt21", 32'(bus.cnt21), 32'd2);
`endif
      // any change in DONE is a bad step
      put(5, 8, 8, 5);
      put(5, 8, 8, 5);
      check_outputs("done_chg", 0, 1, 2, 5, 5);

      // n=0: done one edge after the first sample
      do_reset();
      put(0, 0, 0, 0);
      check("n0.done_early", 32'(bus.done), 32'd0);
      put(0, 0, 0, 0);
      check_outputs("n0", 1, 0, 0, 0, 0);

      // Bad init
      do_reset();
      put(1, 1, 2, 5);
      put(1, 1, 2, 5);
      check_outputs("badinit", 0, 1, 1, 0, 1);

      // n=4, x jumps by 3 at i=2
      do_reset();
      put(0, 0, 0, 4); put(1, 1, 2, 4); put(2, 3, 3, 4);
      put(2, 6, 3, 4);
      check("jump.fail_early", 32'(bus.fail), 32'd0);
      put(2, 6, 3, 4);
      check_outputs("jump", 0, 1, 2, 2, 2);
      put(3, 7, 5, 4);
      put(4, 9, 6, 4);
      check_outputs("jump_frozen", 0, 1, 2, 2, 2);

      // n=3, n changes with an illegal step in the same cycle
      do_reset();
      put(0, 0, 0, 3); put(1, 1, 2, 3);
      put(2, 5, 3, 4);
      put(2, 5, 3, 4);
      check_outputs("nchg", 0, 1, 5, 1, 2);

      // n=2047, full range with x/y wrapping
      do_reset();
      ax = '0; ay = '0;
      put(0, 0, 0, 2047);
      for (int k = 1; k <= 2047; k++) begin
         if (k[0]) begin ax = ax + W'(1); ay = ay + W'(2); end
         else      begin ax = ax + W'(2); ay = ay + W'(1); end
         put(k, int'(ax), int'(ay), 2047);
      end
      check("wrap.done_late", 32'(bus.done), 32'd0);
      put(2047, int'(ax), int'(ay), 2047);
      check_outputs("wrap", 1, 0, 0, 2047, 0);
`ifdef INV93_MON_HIST_EN
      check("wrap.hist_sum", 32'(bus.cnt12) + 32'(bus.cnt21), 32'd2047);
`endif

      // Asynchronous reset mid-run at i=3
      do_reset();
      put(0, 0, 0, 5); put(1, 1, 2, 5); put(2, 3, 3, 5); put(3, 4, 5, 5);
      check("mid.step_cnt_pre", 32'(bus.step_cnt), 32'd2);
      #2 rst = 1'b1;
      #1 check_outputs("mid_rst", 0, 0, 0, 0, 0);
      bus.i = '0; bus.x = '0; bus.y = '0; bus.n = '0;
      @(negedge clk);
      rst = 1'b0;
      put(0, 0, 0, 5); put(1, 1, 2, 5); put(2, 3, 3, 5);
      put(3, 4, 5, 5); put(4, 6, 6, 5); put(5, 7, 8, 5);
      put(5, 7, 8, 5);
      check_outputs("post_rst", 1, 0, 0, 5, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule

// File: doc/inv93_monitor.md
INV93_MONITOR -- requirements
Module: inv93_monitor

Interface
REQ-001 The block SHALL have one clock and asynchronous active-high reset: clk (rising edge), rst (asynchronous, active-high).
REQ-002 Parameter: W, default 11, datapath width of the observed loop variables.
REQ-003 Ports:
- clk  in  1  clock
- rst  in  1  async active-high reset
- i  in  W  loop counter from the loop-body stage
- x  in  W  accumulator x
- y  in  W  accumulator y
- n  in  W  loop bound
- done  out  1  loop terminated legally
- fail  out  1  sticky violation flag
- err_code  out  3  first violation cause
- step_cnt  out  W  legal increments observed
- fail_step  out  W  value of i when the violation was detected

Function
REQ-004 The block SHALL sample i, x, y and n every rising clk edge and compare each sample with the previous one.
REQ-005 The FSM SHALL have states INIT, RUN, DONE and FAIL; FAIL SHALL be absorbing until rst.
REQ-006 INIT: on the first post-reset sample:
- i==x==y==0 and n==0 -> DONE.
- i==x==y==0 and n!=0 -> RUN.
- otherwise -> FAIL with code 1 (bad init).
REQ-007 RUN: a legal step SHALL be either:
- hold: i, x, y unchanged; or
- advance: i'=i+1 and (x'-x, y'-y) equal to (1,2) or (2,1).
All differences SHALL be computed modulo 2^W.
REQ-008 Each advance SHALL increment step_cnt by 1.
REQ-009 An advance that reaches i'==n SHALL move RUN -> DONE in that same cycle; done SHALL assert on the following edge.
REQ-010 DONE SHALL accept only holds; any change to i, x, y or n -> FAIL with code 2 (bad step).
REQ-011 Invariant: every sample in RUN and DONE SHALL satisfy (x+y) mod 2^W == (3*i) mod 2^W; 3*i SHALL be formed at W+2 bits before truncation.
REQ-012 Error codes:
- 0 none
- 1 bad init
- 2 bad step
- 3 invariant broken
- 4 bound exceeded (i>n, unsigned)
- 5 n changed after INIT
REQ-013 If several violations occur in one cycle, the recorded code SHALL follow the priority 5 > 4 > 2 > 3; only the first violation is recorded.
REQ-014 On entry to FAIL: fail=1, err_code and fail_step latched; done=0; step_cnt frozen.
REQ-015 Monitor latency SHALL be one cycle: a violation present in sample k SHALL be visible on fail after edge k+1.

Reset
REQ-016 While rst=1: state=INIT, done=0, fail=0, err_code=0, step_cnt=0, fail_step=0, and stored previous sample=0.
REQ-017 Assertion of rst mid-run SHALL clear all outputs immediately (asynchronously); the first sample after release SHALL be treated as INIT.

Configuration
REQ-018 Macro INV93_MON_HIST_EN:
- Defined: adds outputs cnt12 and cnt21 (W bits each, reset 0) counting (1,2) and (2,1) advances; both freeze in FAIL; cnt12+cnt21 SHALL always equal step_cnt.
- Undefined: these ports and counters SHALL be absent; all other behaviour is identical.

Structure
REQ-019 Package inv93_pkg SHALL hold: the W default, the state enum (INIT/RUN/DONE/FAIL) and the err_code constants.
REQ-020 Sub-module inv93_step_chk (combinational) SHALL classify previous/current samples as hold/adv12/adv21/illegal and compute the invariant-ok flag; the FSM and registers SHALL live in inv93_monitor.

Verification
REQ-021 The bench SHALL cover the following directed scenarios:
- n=5; samples (0,0,0), (1,1,2), (2,3,3), (3,4,5), (4,6,6), (5,7,8) -> done=1, fail=0, step_cnt=5.
- n=0; first sample (0,0,0) -> done=1 one edge after the sample, step_cnt=0.
- n=4; at i=2, x jumps by 3 -> fail=1, err_code=2, fail_step=2.
- n=3; n changes to 4 at step 2, with an illegal step in the same cycle -> err_code=5 (priority).
- n=2047; 2047 advances with x,y wrapping past 2047 -> no invariant fail, done=1 after the final advance.
- rst pulsed mid-run at i=3 -> all outputs 0 immediately; a new sequence starting from (0,0,0) runs cleanly.
